uart_core: RTL
==============

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200: line bit rate.
REQ-003 Parameter DATA_BITS, default 8: data bits per frame; legal 5..8, any other value SHALL fail elaboration.
REQ-004 Parameter PARITY, default 0: 0 none, 1 odd, 2 even; other values SHALL fail elaboration.
REQ-005 Parameter STOP_BITS, default 1: transmitted stop bits, 1 or 2.
REQ-006 clk  input  1  single system clock; all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 tx_data  input  8  byte to send; bits above DATA_BITS-1 ignored.
REQ-009 tx_valid  input  1  source offers tx_data.
REQ-010 tx_ready  output  1  transmitter accepts a byte this cycle.
REQ-011 txd  output  1  serial output, idle high.
REQ-012 rxd  input  1  asynchronous serial input.
REQ-013 rx_data  output  8  received byte, zero-extended above DATA_BITS.
REQ-014 rx_valid  output  1  one-cycle pulse: rx_data and error flags valid.
REQ-015 rx_parity_err  output  1  parity mismatch on frame flagged by rx_valid.
REQ-016 rx_frame_err  output  1  stop bit sampled low on frame flagged by rx_valid.

Function
REQ-017 DIV16 = CLK_FREQ/(16*BAUD), integer truncation; bit period BIT_CLKS = 16*DIV16 (defaults: 27, 432).
REQ-018 Oversample tick: free-running counter 0..DIV16-1, one-cycle tick at DIV16-1.
REQ-019 TX FSM states IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY=0.
REQ-020 tx_ready=1 only in IDLE; transfer occurs on tx_valid&&tx_ready at a rising edge; tx_data latched then; tx_valid while busy ignored.
REQ-021 TX timing: own bit counter cleared on accept; txd low from cycle after accept; every bit exactly BIT_CLKS cycles; data LSB first.
REQ-022 Parity bit: odd -> total ones over data+parity odd; even -> even.
REQ-023 STOP holds txd=1 for STOP_BITS*BIT_CLKS cycles, then IDLE; tx_ready high on the cycle after the last stop cycle, so back-to-back frames have no idle gap beyond 1 cycle.
REQ-024 rxd passes a 2-flop synchroniser (reset value 1) before any use.
REQ-025 RX FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-026 IDLE->START on synchronised falling edge; resample after 8 ticks; if high, false start -> IDLE with no rx_valid.
REQ-027 Subsequent samples every 16 ticks (bit centres): DATA_BITS data LSB first, parity if enabled, one stop bit (only first stop bit checked).
REQ-028 rx_valid pulses the cycle after stop sample, with rx_data, rx_parity_err, rx_frame_err; a frame with errors still pulses rx_valid.
REQ-029 rx_data and flags hold until next rx_valid.
REQ-030 Stop sampled low -> BREAK; remain until synchronised rxd high, then IDLE.
REQ-031 TX and RX are fully independent; simultaneous activity on both SHALL not interact.

Reset
REQ-032 While rst_n low: txd=1, tx_ready=0, rx_valid=0, rx_data=0, both error flags 0, both FSMs IDLE, all counters 0.
REQ-033 tx_ready=1 first cycle after rst_n deasserts; reset mid-frame aborts immediately, txd returns high asynchronously.

Structure
REQ-034 Package uart_pkg holds the parity encoding constants, TX/RX state encodings, and DIV16/BIT_CLKS derivation function.
REQ-035 Sub-module uart_baud_gen implements the oversample tick (REQ-018); TX and RX FSMs live in uart_core.

Verification
REQ-036 Defaults, loopback txd->rxd, send 8'h4A -> txd bit sequence 0,0,1,0,1,0,0,1,0,1 each 432 clocks; rx_valid with rx_data=8'h4A, both errors 0.
REQ-037 PARITY=2, send 8'h4A -> parity bit 1; received rx_parity_err=0; flip that bit on the line -> rx_parity_err=1.
REQ-038 DATA_BITS=7, PARITY=1, send 8'hC1 -> 7'h41 sent, parity bit 1, rx_data=8'h41.
REQ-039 Drive frame 8'h55 with stop bit low -> rx_valid=1, rx_frame_err=1; no new frame accepted until rxd high.
REQ-040 rxd low pulse of 100 clocks -> no rx_valid; tx_valid held high for 8'h55 then 8'hAA -> each frame 4320 clocks, gap at most 1 clock.
REQ-041 rst_n asserted mid-DATA -> txd=1 immediately, tx_ready=1 one cycle after release, no rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encodings and baud derivation
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_e;

    function automatic int unsigned calc_div16(input int clk_freq, input int baud);
        return int'(clk_freq / (16 * baud));
    endfunction

    function automatic int unsigned calc_bit_clks(input int clk_freq, input int baud);
        return 16 * calc_div16(clk_freq, baud);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running 16x oversample tick generator
module uart_baud_gen #(
    parameter int unsigned DIV16 = 27
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam logic [31:0] CNT_LAST = 32'(DIV16 - 1);

    logic [31:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - UART transmitter and 16x oversampled receiver
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err
);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_core: DATA_BITS must be in 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_core: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_core: STOP_BITS must be 1 or 2");
    end

    localparam int unsigned DIV16     = calc_div16(CLK_FREQ, BAUD);
    localparam int unsigned BIT_CLKS  = calc_bit_clks(CLK_FREQ, BAUD);
    localparam logic [31:0] BIT_LAST  = 32'(BIT_CLKS - 1);
    localparam logic [31:0] STOP_LAST = 32'(STOP_BITS * BIT_CLKS - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [7:0]  DATA_MASK = 8'((1 << DATA_BITS) - 1);

    // ---------------- transmitter ----------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [31:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_par_q, tx_par_d;
    logic        txd_q, txd_d;
    logic [7:0]  tx_in;

    assign tx_in    = tx_data & DATA_MASK;
    assign tx_ready = rst_n && (tx_state_q == TX_IDLE);
    assign txd      = txd_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 32'd1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_valid) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_in;
                    tx_par_d   = (PARITY == PAR_ODD) ? ~(^tx_in) : (^tx_in);
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
                        txd_d      = (PARITY != PAR_NONE) ? tx_par_q : 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end
            end
            TX_PARITY: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                    txd_d      = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == STOP_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    // ---------------- receiver ----------------
    logic        rx_tick;
    logic [1:0]  rx_sync_q;
    logic        rx_prev_q;
    logic        rxd_s;
    rx_state_e   rx_state_q, rx_state_d;
    logic [3:0]  rx_tcnt_q, rx_tcnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_pbad_q, rx_pbad_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_perr_q, rx_perr_d;
    logic        rx_ferr_q, rx_ferr_d;

    uart_baud_gen #(.DIV16(DIV16)) u_baud_gen (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .tick_o (rx_tick)
    );

    assign rxd_s         = rx_sync_q[1];
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_pbad_d  = rx_pbad_q;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rxd_s) begin
                    rx_state_d = RX_START;
                    rx_tcnt_d  = '0;
                end
            end
            RX_START: begin
                // Eighth tick lands mid start bit; a high line here was a glitch.
                if (rx_tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd7) begin
                        rx_tcnt_d  = '0;
                        rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
                        rx_bit_d   = '0;
                        rx_shift_d = '0;
                        rx_pbad_d  = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_shift_d[rx_bit_q] = rxd_s;
                        rx_bit_d = rx_bit_q + 3'd1;
                        if (rx_bit_q == LAST_BIT)
                            rx_state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_pbad_d  = ((^rx_shift_q) ^ rxd_s) != (PARITY == PAR_ODD);
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                        rx_perr_d  = rx_pbad_q;
                        rx_ferr_d  = !rxd_s;
                        rx_state_d = rxd_s ? RX_IDLE : RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rxd_s) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_pbad_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], rxd};
            rx_prev_q  <= rxd_s;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_pbad_q  <= rx_pbad_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

endmodule
